// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a word-wide data memory.
// Partial stores become a read cycle followed by a merged full-word write.
module data_memory_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        p0_valid,
    input  logic        p0_write,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_be,
    output logic        p0_ready,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_rdata,
    input  logic        p1_valid,
    input  logic        p1_write,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_be,
    output logic        p1_ready,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic {IDLE, RMW} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] merge_q, merge_d;
    logic        rv0_q, rv0_d;
    logic        rv1_q, rv1_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;

    logic        gnt0, gnt1;
    logic        sel_write;
    logic [29:0] sel_word;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic [31:0] mask;
    logic        unused_lsb;

    assign unused_lsb = ^{p0_addr[1:0], p1_addr[1:0]};

    // On a tie under round-robin, the port that did not win last goes.
    assign gnt0 = p0_valid & (~p1_valid | ~RR_ENABLE | last_q);
    assign gnt1 = p1_valid & ~gnt0;

    assign sel_write = gnt1 ? p1_write       : p0_write;
    assign sel_word  = gnt1 ? p1_addr[31:2]  : p0_addr[31:2];
    assign sel_wdata = gnt1 ? p1_wdata       : p0_wdata;
    assign sel_be    = gnt1 ? p1_be          : p0_be;

    assign mask = {{8{sel_be[3]}}, {8{sel_be[2]}},
                   {8{sel_be[1]}}, {8{sel_be[0]}}};

    always_comb begin
        state_d          = state_q;
        last_d           = last_q;
        addr_d           = addr_q;
        merge_d          = merge_q;
        rv0_d            = 1'b0;
        rv1_d            = 1'b0;
        rd0_d            = rd0_q;
        rd1_d            = rd1_q;
        p0_ready         = 1'b0;
        p1_ready         = 1'b0;
        mem_addr         = 32'h0;
        mem_write_enable = 1'b0;
        mem_write_data   = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    p0_ready = gnt0;
                    p1_ready = gnt1;
                    last_d   = gnt1;
                    mem_addr = {sel_word, 2'b00};
                    unique case (1'b1)
                        !sel_write: begin
                            rv0_d = gnt0;
                            rv1_d = gnt1;
                            if (gnt0) rd0_d = mem_read_data;
                            if (gnt1) rd1_d = mem_read_data;
                        end
                        sel_write && sel_be == 4'hF: begin
                            mem_write_enable = 1'b1;
                            mem_write_data   = sel_wdata;
                        end
                        sel_write && sel_be == 4'h0: begin
                        end
                        default: begin
                            state_d = RMW;
                            addr_d  = {sel_word, 2'b00};
                            merge_d = (mem_read_data & ~mask)
                                    | (sel_wdata & mask);
                        end
                    endcase
                end
            end
            RMW: begin
                mem_addr         = addr_q;
                mem_write_enable = 1'b1;
                mem_write_data   = merge_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset must silence the memory port at once, aborting any RMW write.
        if (!reset_n) begin
            p0_ready         = 1'b0;
            p1_ready         = 1'b0;
            mem_addr         = 32'h0;
            mem_write_enable = 1'b0;
            mem_write_data   = 32'h0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            addr_q  <= 32'h0;
            merge_q <= 32'h0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rd0_q   <= 32'h0;
            rd1_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            merge_q <= merge_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign p0_resp_valid = rv0_q;
    assign p1_resp_valid = rv1_q;
    assign p0_resp_rdata = rd0_q;
    assign p1_resp_rdata = rd1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios then random
// traffic checked against a transaction-level model.
module tb_data_memory_arbiter;

    logic        clock;
    logic        reset_n;
    logic        preload;
    logic        p0_valid, p0_write, p1_valid, p1_write;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_be, p1_be;

    logic        p0_ready, p1_ready, p0_resp_valid, p1_resp_valid;
    logic [31:0] p0_resp_rdata, p1_resp_rdata;
    logic [31:0] a_addr, a_wd, a_rd;
    logic        a_we;

    logic        b_p0_ready, b_p1_ready, b_p0_rv, b_p1_rv;
    logic [31:0] b_p0_rd, b_p1_rd;
    logic [31:0] b_addr, b_wd, b_rd;
    logic        b_we;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] ref_mem [64];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } req_t;

    data_memory_arbiter #(.RR_ENABLE(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .p0_valid(p0_valid), .p0_write(p0_write), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_ready(p0_ready),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
        .p1_valid(p1_valid), .p1_write(p1_write), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_ready(p1_ready),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
        .mem_addr(a_addr), .mem_write_enable(a_we),
        .mem_write_data(a_wd), .mem_read_data(a_rd)
    );

    data_memory_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
        .clock(clock), .reset_n(reset_n),
        .p0_valid(p0_valid), .p0_write(p0_write), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_ready(b_p0_ready),
        .p0_resp_valid(b_p0_rv), .p0_resp_rdata(b_p0_rd),
        .p1_valid(p1_valid), .p1_write(p1_write), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_ready(b_p1_ready),
        .p1_resp_valid(b_p1_rv), .p1_resp_rdata(b_p1_rd),
        .mem_addr(b_addr), .mem_write_enable(b_we),
        .mem_write_data(b_wd), .mem_read_data(b_rd)
    );

    assign a_rd = mem_a[a_addr[7:2]];
    assign b_rd = mem_b[b_addr[7:2]];

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++)
                mem_a[i] <= (i == 2) ? 32'h11223344 : 32'h0;
        end else if (a_we) begin
            mem_a[a_addr[7:2]] <= a_wd;
        end
    end

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++)
                mem_b[i] <= (i == 2) ? 32'h11223344 : 32'h0;
        end else if (b_we) begin
            mem_b[b_addr[7:2]] <= b_wd;
        end
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set0(input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        p0_valid = v; p0_write = w; p0_addr = a; p0_wdata = d; p0_be = be;
    endtask

    task automatic set1(input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        p1_valid = v; p1_write = w; p1_addr = a; p1_wdata = d; p1_be = be;
    endtask

    req_t        rq [2];
    bit          pend [2];
    bit          exp_rv [2];
    logic [31:0] exp_rd [2];
    bit          busy;
    int          rr_last;
    int          g;
    logic [5:0]  idx;
    logic [31:0] word;

    initial begin
        reset_n = 1'b0;
        preload = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        tick();
        tick();
        preload = 1'b0;

        // reset asserted mid-stream with requests present
        reset_n = 1'b1;
        set0(1, 0, 32'h20, 0, 0);
        #2;
        chk("pre_rst_ready", p0_ready, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_p0_ready", p0_ready, 0);
        chk("rst_p1_ready", p1_ready, 0);
        chk("rst_mem_addr", a_addr, 0);
        chk("rst_mem_we", a_we, 0);
        chk("rst_mem_wd", a_wd, 0);
        chk("rst_p0_rv", p0_resp_valid, 0);
        chk("rst_p0_rd", p0_resp_rdata, 0);
        tick();

        // first tie after reset goes to port 0
        reset_n = 1'b1;
        set0(1, 0, 32'h20, 0, 0);
        set1(1, 0, 32'h24, 0, 0);
        #2;
        chk("tie0_p0_ready", p0_ready, 1);
        chk("tie0_p1_ready", p1_ready, 0);
        chk("tie0_mem_addr", a_addr, 32'h20);
        tick();
        chk("tie0_p0_rv", p0_resp_valid, 1);
        chk("tie0_p0_rd", p0_resp_rdata, 0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("rr_p0_ready", p0_ready, (i % 2 == 1) ? 1 : 0);
            chk("rr_p1_ready", p1_ready, (i % 2 == 0) ? 1 : 0);
            chk("fp_p0_ready", b_p0_ready, 1);
            chk("fp_p1_ready", b_p1_ready, 0);
            tick();
            chk("rr_p1_rv", p1_resp_valid, (i % 2 == 0) ? 1 : 0);
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick();

        // full store then load through an unaligned address
        set0(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        #2;
        chk("fs_ready", p0_ready, 1);
        chk("fs_we", a_we, 1);
        chk("fs_wd", a_wd, 32'hDEADBEEF);
        chk("fs_addr", a_addr, 32'h10);
        tick();
        set0(1, 0, 32'h13, 0, 0);
        #2;
        chk("ld13_ready", p0_ready, 1);
        chk("ld13_addr", a_addr, 32'h10);
        chk("ld13_we", a_we, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        chk("ld13_rv", p0_resp_valid, 1);
        chk("ld13_rd", p0_resp_rdata, 32'hDEADBEEF);
        #2;
        chk("idle_addr", a_addr, 0);
        chk("idle_we", a_we, 0);
        tick();
        chk("pulse_rv", p0_resp_valid, 0);

        // partial store from port 1, read back by port 0 in N+2
        set1(1, 1, 32'h08, 32'hAABBCCDD, 4'b0101);
        #2;
        chk("ps_p1_ready", p1_ready, 1);
        chk("ps_rd_we", a_we, 0);
        chk("ps_rd_addr", a_addr, 32'h08);
        tick();
        set1(0, 0, 0, 0, 0);
        set0(1, 0, 32'h08, 0, 0);
        #2;
        chk("rmw_p0_ready", p0_ready, 0);
        chk("rmw_p1_ready", p1_ready, 0);
        chk("rmw_we", a_we, 1);
        chk("rmw_wd", a_wd, 32'h11BB33DD);
        chk("rmw_addr", a_addr, 32'h08);
        tick();
        #2;
        chk("n2_p0_ready", p0_ready, 1);
        tick();
        set0(0, 0, 0, 0, 0);
        chk("n2_rv", p0_resp_valid, 1);
        chk("n2_rd", p0_resp_rdata, 32'h11BB33DD);
        chk("n2_p1_rv", p1_resp_valid, 0);

        // partial store on port 0 blocks a waiting port 1
        set1(1, 0, 32'h30, 0, 0);
        #2;
        chk("blk_pre_p1", p1_ready, 1);
        tick();
        set0(1, 1, 32'h30, 32'h0000BEEF, 4'b0011);
        set1(1, 0, 32'h34, 0, 0);
        #2;
        chk("blk_p0_ready", p0_ready, 1);
        chk("blk_p1_ready", p1_ready, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        #2;
        chk("blk_rmw_p1", p1_ready, 0);
        chk("blk_rmw_we", a_we, 1);
        chk("blk_rmw_wd", a_wd, 32'h0000BEEF);
        tick();
        #2;
        chk("blk_n2_p1", p1_ready, 1);
        chk("blk_n2_addr", a_addr, 32'h34);
        tick();
        set1(0, 0, 0, 0, 0);

        // empty byte enable: accepted, no write
        set0(1, 1, 32'h10, 32'hFFFFFFFF, 4'h0);
        #2;
        chk("be0_ready", p0_ready, 1);
        chk("be0_we", a_we, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        tick();
        chk("be0_mem", mem_a[4], 32'hDEADBEEF);
        chk("ps_mem", mem_a[2], 32'h11BB33DD);

        // reset during RMW aborts the merged write
        set0(1, 1, 32'h40, 32'h000000FF, 4'b0001);
        #2;
        chk("rr_ps_ready", p0_ready, 1);
        tick();
        set0(0, 0, 0, 0, 0);
        #2;
        chk("rr_rmw_we", a_we, 1);
        reset_n = 1'b0;
        #1;
        chk("rr_abort_we", a_we, 0);
        tick();
        chk("rr_mem", mem_a[16], 32'h0);
        reset_n = 1'b1;

        // random traffic against the transaction model
        pend = '{0, 0};
        exp_rv = '{0, 0};
        exp_rd = '{32'h0, 32'h0};
        busy = 1'b0;
        rr_last = 1;
        for (int c = 0; c < 400; c++) begin
            chk("rnd_p0_rv", p0_resp_valid, exp_rv[0]);
            chk("rnd_p1_rv", p1_resp_valid, exp_rv[1]);
            chk("rnd_p0_rd", p0_resp_rdata, exp_rd[0]);
            chk("rnd_p1_rd", p1_resp_rdata, exp_rd[1]);
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 3) != 0) begin
                    rq[k].w = 1'($urandom_range(0, 1));
                    rq[k].a = 32'h80 + (32'($urandom_range(0, 31)) << 2)
                            + 32'($urandom_range(0, 3));
                    rq[k].d = $urandom;
                    case ($urandom_range(0, 3))
                        0: rq[k].be = 4'hF;
                        1: rq[k].be = 4'h0;
                        default: rq[k].be = 4'($urandom_range(0, 15));
                    endcase
                    pend[k] = 1;
                end
            end
            set0(pend[0], rq[0].w, rq[0].a, rq[0].d, rq[0].be);
            set1(pend[1], rq[1].w, rq[1].a, rq[1].d, rq[1].be);
            #2;
            exp_rv = '{0, 0};
            if (busy) begin
                chk("rnd_busy_p0", p0_ready, 0);
                chk("rnd_busy_p1", p1_ready, 0);
                chk("rnd_busy_we", a_we, 1);
                busy = 1'b0;
            end else begin
                g = -1;
                if (pend[0] && pend[1]) g = (rr_last == 0) ? 1 : 0;
                else if (pend[0]) g = 0;
                else if (pend[1]) g = 1;
                chk("rnd_p0_ready", p0_ready, (g == 0) ? 1 : 0);
                chk("rnd_p1_ready", p1_ready, (g == 1) ? 1 : 0);
                if (g >= 0) begin
                    idx = rq[g].a[7:2];
                    chk("rnd_addr", a_addr, {rq[g].a[31:2], 2'b00});
                    chk("rnd_we", a_we,
                        (rq[g].w && rq[g].be == 4'hF) ? 1 : 0);
                    if (!rq[g].w) begin
                        exp_rv[g] = 1;
                        exp_rd[g] = ref_mem[idx];
                    end else if (rq[g].be != 4'h0) begin
                        word = ref_mem[idx];
                        for (int i = 0; i < 4; i++)
                            if (rq[g].be[i]) word[8*i +: 8] = rq[g].d[8*i +: 8];
                        ref_mem[idx] = word;
                        if (rq[g].be != 4'hF) busy = 1'b1;
                    end
                    rr_last = g;
                    pend[g] = 0;
                end
            end
            tick();
        end
        chk("rnd_end_p0_rv", p0_resp_valid, exp_rv[0]);
        chk("rnd_end_p1_rv", p1_resp_valid, exp_rv[1]);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick();
        tick();
        for (int i = 32; i < 64; i++)
            chk("rnd_mem", mem_a[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and sequencer in front of the word-wide `data_memory`. It shares the single memory port between port 0 (pipeline MEM stage) and port 1 (debug/DMA loader) using round-robin or fixed-priority arbitration. It also turns byte-enabled partial stores into read-modify-write sequences, because the memory only supports full-word writes.

## Interface
Parameters:
- `RR_ENABLE`, default 1: 1 selects round-robin on contention; 0 gives port 0 fixed priority.

Ports:
- `clock`  input  1  single clock; all state updates on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `p0_valid`, `p1_valid`  input  1  request present.
- `p0_write`, `p1_write`  input  1  1 = store, 0 = load.
- `p0_addr`, `p1_addr`  input  32  byte address; bits [1:0] are ignored.
- `p0_wdata`, `p1_wdata`  input  32  store data, in byte lanes aligned to the word.
- `p0_be`, `p1_be`  input  4  byte enables; bit i covers bits [8i+7:8i]; ignored for loads.
- `p0_ready`, `p1_ready`  output  1  request accepted this cycle.
- `p0_resp_valid`, `p1_resp_valid`  output  1  load data valid; one-cycle pulse.
- `p0_resp_rdata`, `p1_resp_rdata`  output  32  load data; held until the next load response on that port.
- `mem_addr`  output  32  to `data_memory.addr`; always `{addr[31:2],2'b00}`.
- `mem_write_enable`  output  1  to `data_memory.write_enable`.
- `mem_write_data`  output  32  to `data_memory.write_data`.
- `mem_read_data`  input  32  from `data_memory.read_data`; combinational, same cycle as `mem_addr`.

## Operation
- FSM states:
  - IDLE: arbitrate and serve.
  - RMW: write back a merged word.
- IDLE, grant selection:
  - If only one `pX_valid` is high, grant that port.
  - If both are high and `RR_ENABLE`=1, grant the port that is not `last_grant`.
  - If both are high and `RR_ENABLE`=0, grant port 0.
  - `last_grant` updates to the granted port on every accept.
- IDLE, granted load:
  - `mem_addr` = granted address; `pX_ready`=1.
  - `pX_resp_rdata` <= `mem_read_data` and `pX_resp_valid` <= 1 at the next edge.
  - Stay in IDLE.
- IDLE, granted store with be=4'hF: `mem_write_enable`=1, `mem_write_data`=wdata, `pX_ready`=1; stay in IDLE.
- IDLE, granted store with be=4'h0: `pX_ready`=1, no memory write; stay in IDLE.
- IDLE, granted store with any other be:
  - Drive `mem_addr` and set `pX_ready`=1.
  - Register `addr_q` and `merge_q` = (`mem_read_data` & ~mask) | (wdata & mask), where mask expands be to bytes.
  - Go to RMW.
- RMW:
  - Drive `mem_addr`=`addr_q`, `mem_write_data`=`merge_q`, `mem_write_enable`=1.
  - Both `pX_ready`=0; no grant; return to IDLE.
- Non-granted port: `ready`=0 and must hold its request stable until accepted.
- No request: `mem_addr`=0, `mem_write_enable`=0, `mem_write_data`=0.
- A port that drops `valid` before being accepted has no effect.

## Timing
- Load: accepted in cycle N; `resp_valid` is high in cycle N+1 with data as of cycle N.
- Full or empty store: one cycle. Memory is updated at the end of cycle N.
- Partial store: two cycles (N accept/read, N+1 write). Memory is updated at the end of N+1.
- A request that reaches IDLE in N+2 sees the RMW result, whichever port it comes from.
- Throughput:
  - Loads and full stores: one per cycle.
  - A partial store blocks both ports for one extra cycle.
- Reset (asynchronous, `reset_n`=0):
  - State = IDLE and `last_grant` = 1, so port 0 wins the first tie.
  - All `ready`, `resp_valid`, `resp_rdata`, `mem_*` outputs = 0.
  - `addr_q`/`merge_q` = 0.
- Reset asserted during RMW aborts the write; memory is unchanged.
- Simultaneous `resp_valid` on both ports is impossible, since at most one grant is made per cycle.

## Test plan
- Reset:
  - Hold `reset_n`=0 mid-stream → all outputs 0 immediately.
  - After release, both ports valid → port 0 is granted first.
- Full store then load:
  - p0 stores 0xDEADBEEF to addr 0x10 with be=F → `mem_write_enable` for 1 cycle.
  - p0 then loads 0x10 → `p0_resp_valid` one cycle later with 0xDEADBEEF.
- Partial store:
  - Memory word at 0x08 = 0x11223344; p1 stores 0xAABBCCDD with be=4'b0101.
  - Required: `p1_ready` in N, write in N+1 of 0x11BB33DD; a p0 load of 0x08 in N+2 returns 0x11BB33DD.
- Round-robin contention:
  - Both ports issue loads continuously, `RR_ENABLE`=1 → grants alternate 0,1,0,1.
  - With `RR_ENABLE`=0 → port 0 is always granted and p1 is never ready.
- Partial-store blocking: p0 partial store while p1 is valid → `p1_ready`=0 during RMW, then p1 is granted in N+2.
- Corner cases:
  - Store with be=0 → ready with no `mem_write_enable`.
  - Address 0x13 maps to `mem_addr` 0x10.
  - Reset during RMW → target word unchanged.
